trap_ctrl: RTL and testbench

//  Machine-mode trap sequencer behind the misc exec unit. Accepts one retiring result per

---
 rtl/trap_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_trap_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
//   Machine-mode trap sequencer. Accepts one retiring result per handshake
//   (exception, MRET, or neither) and then runs a fixed four-state sequence:
//   IDLE -> FLUSH (one-cycle flush pulse) -> WB (trap CSR update) -> REDIR
//   (fetch redirect held until accepted). Owns mepc/mcause/mtval/mtvec and the
//   mstatus MIE/MPIE bits.
//
//   Optional feature macro: TRAP_IRQ_EN
//     When defined, adds an external interrupt input (irq, irq_pc). In IDLE a
//     pending irq with mie set wins over any request and is taken as an
//     asynchronous trap with cause 11 (machine external interrupt).
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   req_valid/req_ready      retiring-result handshake (ready only in IDLE)
//   req_pc/req_ex_valid/req_ex/req_ex_tval/req_ret_valid  retiring result
//   irq, irq_pc              (TRAP_IRQ_EN only) interrupt level + resume pc
//   flush                    one-cycle pipeline flush pulse
//   redir_valid/redir_ready/redir_pc  fetch redirect handshake
//   mtvec_we/mtvec_wdata     mtvec write port (usable in any state)
//   mepc/mcause/mtval/mtvec  trap CSRs
//   mstatus_mie/mstatus_mpie interrupt-enable bits
// -----------------------------------------------------------------------------
module trap_ctrl #(
    parameter int              XLEN        = 32,
    parameter int              EXW         = 5,
    parameter logic [XLEN-1:0] RESET_MTVEC = XLEN'(32'h8000_0000)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_pc,
    input  logic            req_ex_valid,
    input  logic [EXW-1:0]  req_ex,
    input  logic [XLEN-1:0] req_ex_tval,
    input  logic            req_ret_valid,
`ifdef TRAP_IRQ_EN
    input  logic            irq,
    input  logic [XLEN-1:0] irq_pc,
`endif
    output logic            flush,
    output logic            redir_valid,
    input  logic            redir_ready,
    output logic [XLEN-1:0] redir_pc,
    input  logic            mtvec_we,
    input  logic [XLEN-1:0] mtvec_wdata,
    output logic [XLEN-1:0] mepc,
    output logic [XLEN-1:0] mcause,
    output logic [XLEN-1:0] mtval,
    output logic [XLEN-1:0] mtvec,
    output logic            mstatus_mie,
    output logic            mstatus_mpie
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FLUSH = 2'd1,
        S_WB    = 2'd2,
        S_REDIR = 2'd3
    } state_t;

    // A NONE result never leaves IDLE, so only the kinds that run the
    // sequence need an encoding.
    typedef enum logic [1:0] {
        K_TRAP = 2'd0,
        K_RET  = 2'd1
`ifdef TRAP_IRQ_EN
        ,
        K_IRQ  = 2'd2
`endif
    } kind_t;

    state_t            state_reg, state_next;
    kind_t             kind_reg, kind_next;
    logic [XLEN-1:0]   pc_reg, pc_next;
    logic [EXW-1:0]    ex_reg, ex_next;
    logic [XLEN-1:0]   tval_reg, tval_next;

    logic              flush_reg, flush_next;
    logic              redir_valid_reg, redir_valid_next;
    logic [XLEN-1:0]   redir_pc_reg, redir_pc_next;

    logic [XLEN-1:0]   mepc_reg, mepc_next;
    logic [XLEN-1:0]   mcause_reg, mcause_next;
    logic [XLEN-1:0]   mtval_reg, mtval_next;
    logic [XLEN-1:0]   mtvec_reg, mtvec_next;
    logic              mie_reg, mie_next;
    logic              mpie_reg, mpie_next;

    logic              take_irq;
    logic              accept;

    // Low mtvec write bits are forced to zero (direct mode, 4-byte aligned).
    logic              unused_wdata_bits;
    assign unused_wdata_bits = ^mtvec_wdata[1:0];

    always_comb begin
        take_irq = 1'b0;
`ifdef TRAP_IRQ_EN
        take_irq = (state_reg == S_IDLE) && irq && mie_reg;
`endif
    end

    assign req_ready = (state_reg == S_IDLE) && !take_irq;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_next       = state_reg;
        kind_next        = kind_reg;
        pc_next          = pc_reg;
        ex_next          = ex_reg;
        tval_next        = tval_reg;
        flush_next       = 1'b0;
        redir_valid_next = redir_valid_reg;
        redir_pc_next    = redir_pc_reg;
        mepc_next        = mepc_reg;
        mcause_next      = mcause_reg;
        mtval_next       = mtval_reg;
        mie_next         = mie_reg;
        mpie_next        = mpie_reg;
        // The WB branch below reads mtvec_reg, so a write landing in the WB
        // cycle only affects later traps.
        mtvec_next       = mtvec_we ? {mtvec_wdata[XLEN-1:2], 2'b00} : mtvec_reg;

        case (state_reg)
            S_IDLE: begin
`ifdef TRAP_IRQ_EN
                if (take_irq) begin
                    kind_next  = K_IRQ;
                    pc_next    = irq_pc;
                    tval_next  = '0;
                    flush_next = 1'b1;
                    state_next = S_FLUSH;
                end else
`endif
                if (accept) begin
                    pc_next   = req_pc;
                    ex_next   = req_ex;
                    tval_next = req_ex_tval;
                    // Exception outranks MRET when both are flagged.
                    if (req_ex_valid) begin
                        kind_next  = K_TRAP;
                        flush_next = 1'b1;
                        state_next = S_FLUSH;
                    end else if (req_ret_valid) begin
                        kind_next  = K_RET;
                        flush_next = 1'b1;
                        state_next = S_FLUSH;
                    end
                end
            end

            S_FLUSH: begin
                state_next = S_WB;
            end

            S_WB: begin
                case (kind_reg)
                    K_TRAP: begin
                        mepc_next     = pc_reg;
                        mcause_next   = {{(XLEN-EXW){1'b0}}, ex_reg};
                        mtval_next    = tval_reg;
                        mpie_next     = mie_reg;
                        mie_next      = 1'b0;
                        redir_pc_next = {mtvec_reg[XLEN-1:2], 2'b00};
                    end
                    K_RET: begin
                        mie_next      = mpie_reg;
                        mpie_next     = 1'b1;
                        redir_pc_next = {mepc_reg[XLEN-1:1], 1'b0};
                    end
`ifdef TRAP_IRQ_EN
                    K_IRQ: begin
                        mepc_next     = pc_reg;
                        mcause_next   = {1'b1, (XLEN-1)'(11)};
                        mtval_next    = '0;
                        mpie_next     = mie_reg;
                        mie_next      = 1'b0;
                        redir_pc_next = {mtvec_reg[XLEN-1:2], 2'b00};
                    end
`endif
                    default: begin
                        redir_pc_next = redir_pc_reg;
                    end
                endcase
                redir_valid_next = 1'b1;
                state_next       = S_REDIR;
            end

            S_REDIR: begin
                if (redir_ready) begin
                    redir_valid_next = 1'b0;
                    state_next       = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg       <= S_IDLE;
            kind_reg        <= K_TRAP;
            pc_reg          <= '0;
            ex_reg          <= '0;
            tval_reg        <= '0;
            flush_reg       <= 1'b0;
            redir_valid_reg <= 1'b0;
            redir_pc_reg    <= '0;
            mepc_reg        <= '0;
            mcause_reg      <= '0;
            mtval_reg       <= '0;
            mtvec_reg       <= RESET_MTVEC;
            mie_reg         <= 1'b0;
            mpie_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            kind_reg        <= kind_next;
            pc_reg          <= pc_next;
            ex_reg          <= ex_next;
            tval_reg        <= tval_next;
            flush_reg       <= flush_next;
            redir_valid_reg <= redir_valid_next;
            redir_pc_reg    <= redir_pc_next;
            mepc_reg        <= mepc_next;
            mcause_reg      <= mcause_next;
            mtval_reg       <= mtval_next;
            mtvec_reg       <= mtvec_next;
            mie_reg         <= mie_next;
            mpie_reg        <= mpie_next;
        end
    end

    assign flush        = flush_reg;
    assign redir_valid  = redir_valid_reg;
    assign redir_pc     = redir_pc_reg;
    assign mepc         = mepc_reg;
    assign mcause       = mcause_reg;
    assign mtval        = mtval_reg;
    assign mtvec        = mtvec_reg;
    assign mstatus_mie  = mie_reg;
    assign mstatus_mpie = mpie_reg;

endmodule

// File: tb/tb_trap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trap_ctrl
//   Self-checking bench for trap_ctrl: reset state, a table of hand-derived
//   transactions, hand-written corner sequences (mtvec write during WB,
//   interrupt priority when TRAP_IRQ_EN is defined, reset during REDIR) and a
//   randomized run checked against a CSR-level reference model.
// -----------------------------------------------------------------------------
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_pc;
    logic        req_ex_valid;
    logic [4:0]  req_ex;
    logic [31:0] req_ex_tval;
    logic        req_ret_valid;
`ifdef TRAP_IRQ_EN
    logic        irq;
    logic [31:0] irq_pc;
`endif
    logic        flush;
    logic        redir_valid;
    logic        redir_ready;
    logic [31:0] redir_pc;
    logic        mtvec_we;
    logic [31:0] mtvec_wdata;
    logic [31:0] mepc, mcause, mtval, mtvec;
    logic        mstatus_mie, mstatus_mpie;

    int tests    = 0;
    int failures = 0;
    int txn_no   = 0;

    // Reference model state: the architectural trap CSRs.
    logic [31:0] m_mepc, m_mcause, m_mtval, m_mtvec;
    logic        m_mie, m_mpie;

    always #5 clk = ~clk;

    trap_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_pc       (req_pc),
        .req_ex_valid (req_ex_valid),
        .req_ex       (req_ex),
        .req_ex_tval  (req_ex_tval),
        .req_ret_valid(req_ret_valid),
`ifdef TRAP_IRQ_EN
        .irq          (irq),
        .irq_pc       (irq_pc),
`endif
        .flush        (flush),
        .redir_valid  (redir_valid),
        .redir_ready  (redir_ready),
        .redir_pc     (redir_pc),
        .mtvec_we     (mtvec_we),
        .mtvec_wdata  (mtvec_wdata),
        .mepc         (mepc),
        .mcause       (mcause),
        .mtval        (mtval),
        .mtvec        (mtvec),
        .mstatus_mie  (mstatus_mie),
        .mstatus_mpie (mstatus_mpie)
    );

    typedef struct {
        logic        exv;
        logic        retv;
        logic [31:0] pc;
        logic [4:0]  ex;
        logic [31:0] tval;
        int          stall;
        logic        e_flush;
        logic [31:0] e_mepc;
        logic [31:0] e_mcause;
        logic [31:0] e_mtval;
        logic        e_mie;
        logic        e_mpie;
        logic [31:0] e_redir;
    } vec_t;

    vec_t tab [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mepc   = 32'h0;
        m_mcause = 32'h0;
        m_mtval  = 32'h0;
        m_mtvec  = 32'h8000_0000;
        m_mie    = 1'b0;
        m_mpie   = 1'b0;
    endtask

    task automatic chk_csrs(input string tag);
        chk({tag, "_mepc"},   mepc,   m_mepc);
        chk({tag, "_mcause"}, mcause, m_mcause);
        chk({tag, "_mtval"},  mtval,  m_mtval);
        chk({tag, "_mtvec"},  mtvec,  m_mtvec);
        chk({tag, "_mie"},    32'(mstatus_mie),  32'(m_mie));
        chk({tag, "_mpie"},   32'(mstatus_mpie), 32'(m_mpie));
    endtask

    // Called at a negedge with the DUT idle. Runs one request through the
    // whole sequence and leaves the bench at the negedge after completion.
    // wbw/wbd place an mtvec write in the WB cycle.
    task automatic run_txn(input logic exv, input logic retv, input logic [31:0] pc,
                           input logic [4:0] ex, input logic [31:0] tval, input int stall,
                           input logic wbw, input logic [31:0] wbd,
                           output logic obs_flush, output logic [31:0] obs_redir);
        logic [31:0] exp_redir;
        logic        active;
        active = exv || retv;
        txn_no++;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid     = 1'b1;
        req_pc        = pc;
        req_ex_valid  = exv;
        req_ex        = ex;
        req_ex_tval   = tval;
        req_ret_valid = retv;
        @(negedge clk);                         // T+1
        req_valid     = 1'b0;
        req_ex_valid  = 1'b0;
        req_ret_valid = 1'b0;
        obs_flush = flush;
        obs_redir = redir_pc;
        chk("flush_t1", 32'(flush), 32'(active));
        if (!active) begin
            chk("ready_after_none", 32'(req_ready), 32'd1);
            chk_csrs("none");
            $display("[TB] txn %0d NONE pc=%h", txn_no, pc);
            return;
        end
        chk("ready_busy", 32'(req_ready), 32'd0);
        if (exv) begin
            m_mepc    = pc;
            m_mcause  = 32'(ex);
            m_mtval   = tval;
            m_mpie    = m_mie;
            m_mie     = 1'b0;
            exp_redir = m_mtvec & ~32'h3;
        end else begin
            m_mie     = m_mpie;
            m_mpie    = 1'b1;
            exp_redir = m_mepc & ~32'h1;
        end
        @(negedge clk);                         // T+2 (WB)
        chk("flush_t2", 32'(flush), 32'd0);
        chk("redir_early", 32'(redir_valid), 32'd0);
        if (wbw) begin
            mtvec_we    = 1'b1;
            mtvec_wdata = wbd;
            m_mtvec     = wbd & ~32'h3;
        end
        @(negedge clk);                         // T+3
        mtvec_we = 1'b0;
        chk("redir_valid_t3", 32'(redir_valid), 32'd1);
        chk("redir_pc", redir_pc, exp_redir);
        obs_redir = redir_pc;
        chk_csrs(exv ? "trap" : "ret");
        redir_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("redir_valid_hold", 32'(redir_valid), 32'd1);
            chk("redir_pc_hold", redir_pc, exp_redir);
            chk("ready_during_redir", 32'(req_ready), 32'd0);
        end
        redir_ready = 1'b1;
        @(negedge clk);
        redir_ready = 1'b0;
        chk("redir_done", 32'(redir_valid), 32'd0);
        chk("ready_after_redir", 32'(req_ready), 32'd1);
        $display("[TB] txn %0d %s pc=%h ex=%0d redir=%h stall=%0d", txn_no,
                 exv ? "TRAP" : "MRET", pc, ex, obs_redir, stall);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_redir_valid", 32'(redir_valid), 32'd0);
        chk("rst_redir_pc", redir_pc, 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk_csrs("rst");
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic        of;
        logic [31:0] orr;
        logic [31:0] rpc, rtval, wd;
        logic [4:0]  rex;
        int          kind, st;
        logic        wbw;

        rst = 1'b0;
        req_valid = 1'b0; req_pc = '0; req_ex_valid = 1'b0; req_ex = '0;
        req_ex_tval = '0; req_ret_valid = 1'b0;
        redir_ready = 1'b0; mtvec_we = 1'b0; mtvec_wdata = '0;
`ifdef TRAP_IRQ_EN
        irq = 1'b0; irq_pc = '0;
`endif
        model_reset();

        //          exv   retv  pc          ex     tval          st fl    mepc        mcause  mtval         mie   mpie  redir
        tab[0] = '{1'b0, 1'b0, 32'h10,  5'd0,  32'h0,         0, 1'b0, 32'h0,   32'h0,  32'h0,        1'b0, 1'b0, 32'h0};
        tab[1] = '{1'b0, 1'b1, 32'h20,  5'd0,  32'h0,         0, 1'b1, 32'h0,   32'h0,  32'h0,        1'b0, 1'b1, 32'h0};
        tab[2] = '{1'b0, 1'b1, 32'h24,  5'd0,  32'h0,         0, 1'b1, 32'h0,   32'h0,  32'h0,        1'b1, 1'b1, 32'h0};
        tab[3] = '{1'b1, 1'b0, 32'h100, 5'd2,  32'hDEAD_BEEF, 0, 1'b1, 32'h100, 32'h2,  32'hDEAD_BEEF, 1'b0, 1'b1, 32'h8000_0000};
        tab[4] = '{1'b0, 1'b1, 32'h104, 5'd0,  32'h0,         0, 1'b1, 32'h100, 32'h2,  32'hDEAD_BEEF, 1'b1, 1'b1, 32'h100};
        tab[5] = '{1'b1, 1'b0, 32'h101, 5'd3,  32'h0,         0, 1'b1, 32'h101, 32'h3,  32'h0,        1'b0, 1'b1, 32'h8000_0000};
        tab[6] = '{1'b0, 1'b1, 32'h108, 5'd0,  32'h0,         2, 1'b1, 32'h101, 32'h3,  32'h0,        1'b1, 1'b1, 32'h100};
        tab[7] = '{1'b1, 1'b1, 32'h40,  5'd2,  32'h5,         5, 1'b1, 32'h40,  32'h2,  32'h5,        1'b0, 1'b1, 32'h8000_0000};
        tab[8] = '{1'b1, 1'b0, 32'h44,  5'd31, 32'h1,         1, 1'b1, 32'h44,  32'h1F, 32'h1,        1'b0, 1'b0, 32'h8000_0000};

        do_reset();

        for (int i = 0; i < 9; i++) begin
            run_txn(tab[i].exv, tab[i].retv, tab[i].pc, tab[i].ex, tab[i].tval,
                    tab[i].stall, 1'b0, 32'h0, of, orr);
            chk("tab_flush",  32'(of), 32'(tab[i].e_flush));
            chk("tab_redir",  orr, tab[i].e_redir);
            chk("tab_mepc",   mepc, tab[i].e_mepc);
            chk("tab_mcause", mcause, tab[i].e_mcause);
            chk("tab_mtval",  mtval, tab[i].e_mtval);
            chk("tab_mie",    32'(mstatus_mie), 32'(tab[i].e_mie));
            chk("tab_mpie",   32'(mstatus_mpie), 32'(tab[i].e_mpie));
        end

        // mtvec write while idle: low two bits dropped, visible next cycle.
        mtvec_we = 1'b1; mtvec_wdata = 32'h1234_5677;
        @(negedge clk);
        mtvec_we = 1'b0;
        m_mtvec = 32'h1234_5674;
        chk("mtvec_idle_write", mtvec, 32'h1234_5674);
        $display("[TB] mtvec write %h -> %h", 32'h1234_5677, mtvec);

        // mtvec write in the WB cycle: the trap still vectors to the old base.
        run_txn(1'b1, 1'b0, 32'h50, 5'd7, 32'h9, 0, 1'b1, 32'h0000_4003, of, orr);
        chk("wb_write_old_base", orr, 32'h1234_5674);
        chk("wb_write_new_mtvec", mtvec, 32'h0000_4000);

`ifdef TRAP_IRQ_EN
        // Two MRETs bring mie to 1 (mpie is forced to 1 by the first).
        run_txn(1'b0, 1'b1, 32'h60, 5'd0, 32'h0, 0, 1'b0, 32'h0, of, orr);
        run_txn(1'b0, 1'b1, 32'h64, 5'd0, 32'h0, 0, 1'b0, 32'h0, of, orr);
        chk("irq_pre_mie", 32'(mstatus_mie), 32'd1);
        irq = 1'b1; irq_pc = 32'h200;
        req_valid = 1'b1; req_ret_valid = 1'b1; req_pc = 32'h300;
        #1;
        chk("irq_blocks_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        irq = 1'b0; req_valid = 1'b0; req_ret_valid = 1'b0;
        chk("irq_flush", 32'(flush), 32'd1);
        @(negedge clk);
        @(negedge clk);
        m_mepc = 32'h200; m_mcause = 32'h8000_000B; m_mtval = 32'h0;
        m_mpie = m_mie; m_mie = 1'b0;
        chk("irq_redir_valid", 32'(redir_valid), 32'd1);
        chk("irq_redir_pc", redir_pc, m_mtvec);
        chk_csrs("irq");
        redir_ready = 1'b1;
        @(negedge clk);
        redir_ready = 1'b0;
        chk("irq_done", 32'(redir_valid), 32'd0);
        $display("[TB] irq pc=%h mcause=%h redir=%h", 32'h200, mcause, m_mtvec);
        // mie is now 0: irq must be ignored.
        irq = 1'b1; irq_pc = 32'h240; req_valid = 1'b1;
        #1;
        chk("irq_masked_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        irq = 1'b0; req_valid = 1'b0;
        chk("irq_masked_noflush", 32'(flush), 32'd0);
        chk("irq_masked_mepc", mepc, m_mepc);
`endif

        // Reset while REDIR is stalled drops the redirect.
        req_valid = 1'b1; req_ex_valid = 1'b1; req_pc = 32'h300; req_ex = 5'd4;
        @(negedge clk);
        req_valid = 1'b0; req_ex_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_redir_up", 32'(redir_valid), 32'd1);
        @(negedge clk);
        chk("midrst_redir_held", 32'(redir_valid), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_redir_drop", 32'(redir_valid), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd1);
        chk("midrst_redir_pc", redir_pc, 32'd0);
        chk("midrst_mtvec", mtvec, 32'h8000_0000);
        $display("[TB] reset during REDIR");
        do_reset();

        // Randomized transactions against the model.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                wd = $urandom;
                mtvec_we = 1'b1; mtvec_wdata = wd;
                @(negedge clk);
                mtvec_we = 1'b0;
                m_mtvec = wd & ~32'h3;
                chk("rnd_mtvec", mtvec, m_mtvec);
            end
            kind  = int'($urandom_range(0, 3));
            rpc   = $urandom;
            rex   = 5'($urandom);
            rtval = $urandom;
            st    = int'($urandom_range(0, 3));
            wbw   = ($urandom_range(0, 3) == 0);
            wd    = $urandom;
            run_txn(kind == 1 || kind == 3, kind == 2 || kind == 3, rpc, rex, rtval,
                    st, wbw, wd, of, orr);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
